axil_mem_slave: RTL
===================

Name: axil_mem_slave

Overview:
AXI4-Lite responder (slave) that terminates the processor-side AXI4-Lite master bus and drives a single-port synchronous word memory (or a memory-like peripheral).
- Accepts one transaction at a time.
- Translates it into a byte-strobed memory write or a 1-cycle-latency memory read.
- Returns the B or R response with OKAY for in-range addresses and SLVERR for out-of-range addresses.
- Sits behind the LSU interconnect's AXI4-Lite port as the first bus-attached memory region.

Parameters:
- ADDR_MEM_WIDTH, 10, word-address width of the memory; depth is 2**ADDR_MEM_WIDTH words.
- MEM_BASE, 32'h2000_0000, byte base address of the region.
- MEM_LENGTH, 32'h1 << (ADDR_MEM_WIDTH+2), region length in bytes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  reset; synchronous, active-high (1 = reset).
- awaddr  in  32  write address.
- awprot  in  3  ignored.
- awvalid  in  1
- awready  out  1
- wdata  in  32
- wstrb  in  4  byte enables.
- wvalid  in  1
- wready  out  1
- bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- bvalid  out  1
- bready  in  1
- araddr  in  32
- arprot  in  3  ignored.
- arvalid  in  1
- arready  out  1
- rdata  out  32
- rresp  out  2
- rvalid  out  1
- rready  in  1
- we_mem  out  1  memory write enable, 1-cycle pulse.
- wstrb_mem  out  4
- addr_mem  out  ADDR_MEM_WIDTH  word address.
- din_mem  out  32
- dout_mem  in  32  memory read data, valid one cycle after addr_mem is presented.

Behaviour:
- FSM states: IDLE, B_RESP, R_WAIT, R_RESP. Reset state is IDLE.
- Reset values (nrst=1 at a clock edge):
  - awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=2'b00; rdata=0; we_mem=0; wstrb_mem=0; addr_mem=0; din_mem=0.
- In-range test:
  - MEM_BASE <= addr < MEM_BASE+MEM_LENGTH, compared in 32 bits.
  - off = addr - MEM_BASE.
  - addr_mem = off[ADDR_MEM_WIDTH+1:2]; address bits [1:0] are ignored (no alignment check).
- IDLE ready generation (combinational on the valids):
  - awready = wready = awvalid & wvalid. AW and W are accepted only together, in the same cycle.
  - arready = arvalid & ~(awvalid & wvalid). A write wins over a simultaneous read; the read stays pending.
  - All readies are 0 in every other state.
- Write handshake (cycle T, IDLE):
  - If in range: we_mem=1, wstrb_mem=wstrb, addr_mem from awaddr, din_mem=wdata, combinational in cycle T only.
  - If out of range: we_mem=0, wstrb_mem=0, addr_mem=0, din_mem=0.
  - Next state B_RESP. bvalid=1 from T+1; bresp = OKAY or SLVERR.
- B_RESP: hold bvalid and bresp stable until bready=1; on that edge return to IDLE. Earliest next accept is the cycle after.
- Read handshake (cycle T, IDLE):
  - addr_mem from araddr (0 if out of range); we_mem=0.
  - Latch the in-range flag. Next state R_WAIT.
- R_WAIT (T+1):
  - addr_mem holds the latched address.
  - rdata <= dout_mem if in range, else 32'hDEAD_BEEF.
  - rresp <= OKAY or SLVERR.
  - Next state R_RESP.
- R_RESP (T+2 onward): rvalid=1 with rdata and rresp stable until rready=1; then return to IDLE.
- Read-to-rvalid latency is 2 cycles. Write-to-bvalid latency is 1 cycle.
- Outside a write-handshake cycle, we_mem=0 always. There is never more than one memory write per AW/W pair.
- awvalid without wvalid (or the reverse) is never accepted; the bus waits with no side effect.
- Back-to-back transactions:
  - No pipelining: at most one outstanding transaction.
  - A response-accept edge and a new request in the same cycle: the new request is seen in IDLE on the following cycle.
- Reset mid-operation: the FSM returns to IDLE and bvalid/rvalid drop in the next cycle. A pending response is discarded and no further memory write occurs.
- wstrb=4'b0000 in range: still a legal write; we_mem=1 with wstrb_mem=0, and the response is OKAY.

Test Plan:
- Reset: hold nrst=1 for 3 cycles with random inputs -> all outputs at their reset values; awready=arready=0.
- Write then read: AW/W to 0x2000_0010, data 0xCAFE_F00D, wstrb 4'hF.
  - Required: we_mem=1 for exactly one cycle, addr_mem=4, bvalid at T+1 with OKAY.
  - Then AR to 0x2000_0010 -> rvalid at T+2, rdata=0xCAFE_F00D, OKAY.
- Partial write: wstrb=4'b0010, wdata=0x0000_AB00 at 0x2000_0010 -> a subsequent read returns 0xCAFE_ABOD with only byte 1 changed (0xCAFEAB0D).
- Out of range: write to 0x2000_1000 -> no we_mem pulse, bresp=2'b10. Read of 0x1FFF_FFFC -> rdata=0xDEAD_BEEF, rresp=2'b10.
- Simultaneous AW+W+AR in one cycle -> the write is accepted first. arready=1 only after the B handshake, and the read returns the newly written data.
- Backpressure and reset: hold bready=0 for 5 cycles -> bvalid and bresp stable throughout. Assert nrst during R_RESP -> rvalid=0 on the next cycle and the FSM is back in IDLE.

Source files
------------

// File: rtl/axil_mem_slave.sv
// AXI4-Lite responder that fronts a single-port synchronous word memory, one transaction at a time.
// Latency: write handshake to bvalid 1 cycle, read handshake to rvalid 2 cycles (1-cycle memory read).
// Backpressure: no readies while a response is outstanding; bvalid/rvalid held with stable data until accepted.
module axil_mem_slave #(
    parameter int unsigned ADDR_MEM_WIDTH = 10,
    parameter logic [31:0] MEM_BASE       = 32'h2000_0000,
    parameter logic [31:0] MEM_LENGTH     = 32'h1 << (ADDR_MEM_WIDTH + 2)
) (
    input  logic                      clk,
    input  logic                      nrst,

    input  logic [31:0]               awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,

    input  logic [31:0]               wdata,
    input  logic [3:0]                wstrb,
    input  logic                      wvalid,
    output logic                      wready,

    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,

    input  logic [31:0]               araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,

    output logic [31:0]               rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,

    output logic                      we_mem,
    output logic [3:0]                wstrb_mem,
    output logic [ADDR_MEM_WIDTH-1:0] addr_mem,
    output logic [31:0]               din_mem,
    input  logic [31:0]               dout_mem
);

    localparam logic [31:0] MEM_END     = MEM_BASE + MEM_LENGTH;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        B_RESP = 2'd1,
        R_WAIT = 2'd2,
        R_RESP = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Address decode for both channels; byte-lane bits [1:0] are simply dropped.
    logic [31:0]               aw_off;
    logic [31:0]               ar_off;
    logic                      aw_in_range;
    logic                      ar_in_range;
    logic [ADDR_MEM_WIDTH-1:0] aw_word;
    logic [ADDR_MEM_WIDTH-1:0] ar_word;

    assign aw_off      = awaddr - MEM_BASE;
    assign ar_off      = araddr - MEM_BASE;
    assign aw_in_range = (awaddr >= MEM_BASE) && (awaddr < MEM_END);
    assign ar_in_range = (araddr >= MEM_BASE) && (araddr < MEM_END);
    assign aw_word     = aw_off[ADDR_MEM_WIDTH+1:2];
    assign ar_word     = ar_off[ADDR_MEM_WIDTH+1:2];

    // Protection bits and the offset bits outside the word index carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, aw_off[1:0], ar_off[1:0],
                           aw_off[31:ADDR_MEM_WIDTH+2], ar_off[31:ADDR_MEM_WIDTH+2]};

    // Request arbitration in IDLE: AW and W must arrive together, and a write beats a read.
    logic wr_req;
    logic rd_req;

    assign wr_req = awvalid & wvalid;
    assign rd_req = arvalid & ~wr_req;

    // Latched read context and registered response fields.
    logic [ADDR_MEM_WIDTH-1:0] rd_addr_q;
    logic                      rd_in_range_q;
    logic [1:0]                bresp_q;
    logic [1:0]                rresp_q;
    logic [31:0]               rdata_q;

    assign bvalid = (state_q == B_RESP);
    assign rvalid = (state_q == R_RESP);
    assign bresp  = bresp_q;
    assign rresp  = rresp_q;
    assign rdata  = rdata_q;

    // Next-state, channel readies and memory port drive; everything quiet while reset is held.
    always_comb begin
        state_d   = state_q;
        awready   = 1'b0;
        wready    = 1'b0;
        arready   = 1'b0;
        we_mem    = 1'b0;
        wstrb_mem = 4'b0000;
        addr_mem  = '0;
        din_mem   = 32'h0;
        if (!nrst) begin
            case (state_q)
                IDLE: begin
                    awready = wr_req;
                    wready  = wr_req;
                    arready = rd_req;
                    if (wr_req) begin
                        if (aw_in_range) begin
                            we_mem    = 1'b1;
                            wstrb_mem = wstrb;
                            addr_mem  = aw_word;
                            din_mem   = wdata;
                        end
                        state_d = B_RESP;
                    end else if (rd_req) begin
                        addr_mem = ar_in_range ? ar_word : '0;
                        state_d  = R_WAIT;
                    end
                end
                B_RESP: begin
                    if (bready) begin
                        state_d = IDLE;
                    end
                end
                R_WAIT: begin
                    // Keep the address on the port so the memory output stays valid into the capture edge.
                    addr_mem = rd_addr_q;
                    state_d  = R_RESP;
                end
                R_RESP: begin
                    if (rready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset; a reset discards any pending response.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response and read-context registers, loaded at the handshake edge and in R_WAIT.
    always_ff @(posedge clk) begin
        if (nrst) begin
            bresp_q       <= RESP_OKAY;
            rresp_q       <= RESP_OKAY;
            rdata_q       <= 32'h0;
            rd_addr_q     <= '0;
            rd_in_range_q <= 1'b0;
        end else begin
            if (state_q == IDLE && wr_req) begin
                bresp_q <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (state_q == IDLE && rd_req) begin
                rd_addr_q     <= ar_in_range ? ar_word : '0;
                rd_in_range_q <= ar_in_range;
            end
            if (state_q == R_WAIT) begin
                rdata_q <= rd_in_range_q ? dout_mem : RD_ERR_DATA;
                rresp_q <= rd_in_range_q ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule
